// File: rtl/ro_sts_pkg.sv
// Shared definitions for read-only status register banks (ro_sts_bank, ro_reg users).
// Latency: none (constants and combinational helpers only).
// Backpressure: not applicable.
package ro_sts_pkg;

  // Largest supported register count per bank; NUM_REG must stay in 1..STS_MAX_NUM_REG.
  localparam int STS_MAX_NUM_REG = 16;

  // A read is allowed when at least one active mode has reads enabled for this bank.
  function automatic logic sts_mode_rd_ok(
    input logic test_mode,
    input logic cfg_mode,
    input logic sup_test,
    input logic sup_cfg
  );
    return (test_mode & sup_test) | (cfg_mode & sup_cfg);
  endfunction

endpackage

// File: rtl/sts_sticky_cell.sv
// One DW-wide register of sticky status bits: set by event, cleared on read.
// Latency: set/clear take effect at the next clock edge.
// Backpressure: none; set has priority over a same-cycle clear.
//
// Ports:
//   i_clk    - clock
//   i_rst    - synchronous active-high reset, overrides set and clear
//   i_set    - per-bit set request (already masked to sticky bits)
//   i_clr    - per-bit clear request (bits returned as 1 by a read)
//   o_sticky - current sticky state
module sts_sticky_cell #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_set,
  input  logic [DW-1:0] i_clr,
  output logic [DW-1:0] o_sticky
);

  logic [DW-1:0] sticky_q;
  logic [DW-1:0] sticky_d;

  // Clear first, then OR in the set so an event coinciding with a read survives.
  always_comb begin
    sticky_d = (sticky_q & ~i_clr) | i_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign o_sticky = sticky_q;

endmodule

// File: rtl/ro_sts_bank.sv
// Bank of NUM_REG read-only status registers mixing live and sticky (read-clear) bits.
// Latency: read data and valid are registered, exactly one cycle after the accepted read.
// Backpressure: none; a read is accepted whenever it hits and a read mode allows it.
//
// Ports:
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_ren, i_addr          - read strobe and address (register k at BASE_ADDR+k)
//   i_test_mode_status     - test mode flag
//   i_cfg_mode_status      - cfg mode flag
//   i_ff_data              - status inputs, register k on [k*DW +: DW]
//   o_rdata, o_rvld        - read data (zero when not valid) and valid
//   i_irq_en, o_irq        - only with RO_STS_BANK_IRQ_EN defined: per-bit interrupt
//                            enable and registered OR of enabled sticky bits
module ro_sts_bank
  import ro_sts_pkg::*;
#(
  parameter int                    DW                   = 8,
  parameter int                    AW                   = 8,
  parameter int                    NUM_REG              = 4,
  parameter int                    BASE_ADDR            = 0,
  parameter logic [NUM_REG*DW-1:0] STICKY_MASK          = '0,
  parameter bit                    SUPPORT_TEST_MODE_RD = 1'b1,
  parameter bit                    SUPPORT_CFG_MODE_RD  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ren,
  input  logic                  i_test_mode_status,
  input  logic                  i_cfg_mode_status,
  input  logic [AW-1:0]         i_addr,
  input  logic [NUM_REG*DW-1:0] i_ff_data,
`ifdef RO_STS_BANK_IRQ_EN
  input  logic [NUM_REG*DW-1:0] i_irq_en,
  output logic                  o_irq,
`endif
  output logic [DW-1:0]         o_rdata,
  output logic                  o_rvld
);

  // One extra bit so the offset subtraction cannot wrap into a false hit.
  localparam int OFFW = AW + 1;

  logic [OFFW-1:0]       addr_ext;
  logic [OFFW-1:0]       base_ext;
  logic [OFFW-1:0]       off;
  logic                  hit;
  logic                  rd_ok;
  logic [NUM_REG-1:0]    sel;
  logic [NUM_REG*DW-1:0] set_vec;
  logic [NUM_REG*DW-1:0] clr_vec;
  logic [NUM_REG*DW-1:0] sticky_vec;
  logic [DW-1:0]         rd_val;

  logic [DW-1:0]         rdata_q;
  logic [DW-1:0]         rdata_d;
  logic                  rvld_q;
  logic                  rvld_d;

  always_comb begin
    addr_ext = {1'b0, i_addr};
    base_ext = OFFW'(BASE_ADDR);
    off      = addr_ext - base_ext;
    hit      = (addr_ext >= base_ext) && (off < OFFW'(NUM_REG));
    rd_ok    = i_ren & hit & sts_mode_rd_ok(i_test_mode_status, i_cfg_mode_status,
                                            SUPPORT_TEST_MODE_RD, SUPPORT_CFG_MODE_RD);

    // Only sticky bit positions can ever be stored.
    set_vec  = i_ff_data & STICKY_MASK;

    sel      = '0;
    rd_val   = '0;
    clr_vec  = '0;
    for (int k = 0; k < NUM_REG; k++) begin
      sel[k] = rd_ok && (off == OFFW'(k));
      if (sel[k]) begin
        // Sticky view includes this cycle's set so a coinciding event is reported.
        rd_val = rd_val
               | sticky_vec[k*DW +: DW]
               | set_vec[k*DW +: DW]
               | (i_ff_data[k*DW +: DW] & ~STICKY_MASK[k*DW +: DW]);
        // Clear what the read returned; the cell's set priority keeps re-set bits.
        clr_vec[k*DW +: DW] = sticky_vec[k*DW +: DW];
      end
    end

    rvld_d  = rd_ok;
    rdata_d = rd_ok ? rd_val : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  assign o_rdata = rdata_q;
  assign o_rvld  = rvld_q;

  for (genvar k = 0; k < NUM_REG; k++) begin : g_cell
    sts_sticky_cell #(
      .DW(DW)
    ) u_cell (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_set   (set_vec[k*DW +: DW]),
      .i_clr   (clr_vec[k*DW +: DW]),
      .o_sticky(sticky_vec[k*DW +: DW])
    );
  end

`ifdef RO_STS_BANK_IRQ_EN
  logic irq_q;
  logic irq_d;

  always_comb begin
    irq_d = |(sticky_vec & i_irq_en);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_ro_sts_bank.sv
// Directed bench for ro_sts_bank: two instances sharing stimulus, one with test-mode reads disabled.
module tb_ro_sts_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren;
  logic        test_mode;
  logic        cfg_mode;
  logic [7:0]  addr;
  logic [31:0] ff;
  logic [7:0]  rdata0, rdata1;
  logic        rvld0, rvld1;
`ifdef RO_STS_BANK_IRQ_EN
  logic [31:0] irq_en;
  logic        irq0, irq1;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] MASK = 32'h00FF_F000;  // reg1 upper nibble, reg2 all sticky

  always #5 clk = ~clk;

  ro_sts_bank #(
    .DW(8), .AW(8), .NUM_REG(4), .BASE_ADDR(8'h10), .STICKY_MASK(MASK),
    .SUPPORT_TEST_MODE_RD(1'b1), .SUPPORT_CFG_MODE_RD(1'b1)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_ren(ren),
    .i_test_mode_status(test_mode), .i_cfg_mode_status(cfg_mode),
    .i_addr(addr), .i_ff_data(ff),
`ifdef RO_STS_BANK_IRQ_EN
    .i_irq_en(irq_en), .o_irq(irq0),
`endif
    .o_rdata(rdata0), .o_rvld(rvld0)
  );

  ro_sts_bank #(
    .DW(8), .AW(8), .NUM_REG(4), .BASE_ADDR(8'h10), .STICKY_MASK(MASK),
    .SUPPORT_TEST_MODE_RD(1'b0), .SUPPORT_CFG_MODE_RD(1'b1)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_ren(ren),
    .i_test_mode_status(test_mode), .i_cfg_mode_status(cfg_mode),
    .i_addr(addr), .i_ff_data(ff),
`ifdef RO_STS_BANK_IRQ_EN
    .i_irq_en(irq_en), .o_irq(irq1),
`endif
    .o_rdata(rdata1), .o_rvld(rvld1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic vld, input logic [7:0] dat);
    chk({tag, ".vld0"}, {31'd0, rvld0}, {31'd0, vld});
    chk({tag, ".dat0"}, {24'd0, rdata0}, {24'd0, dat});
    chk({tag, ".vld1"}, {31'd0, rvld1}, {31'd0, vld});
    chk({tag, ".dat1"}, {24'd0, rdata1}, {24'd0, dat});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ren = 1'b0; test_mode = 1'b0; cfg_mode = 1'b1;
    addr = 8'h00; ff = '0;
`ifdef RO_STS_BANK_IRQ_EN
    irq_en = 32'h0001_0000;
`endif
    // Reset with a concurrent read: no valid afterwards.
    ren = 1'b1; addr = 8'h11;
    tick();
    chk_both("reset", 1'b0, 8'h00);
    rst = 1'b0; ren = 1'b0;
    tick();
    chk_both("post_reset", 1'b0, 8'h00);

    // Pulse reg1 = 0x30, then read twice: sticky value then cleared.
    ff = 32'h0000_3000;
    tick();
    ff = '0; ren = 1'b1; addr = 8'h11;
    tick();
    chk_both("rd1_sticky", 1'b1, 8'h30);
    tick();
    chk_both("rd1_cleared", 1'b1, 8'h00);
    ren = 1'b0;
    tick();
    chk_both("idle", 1'b0, 8'h00);

    // Live bits follow the input sampled in the read cycle.
    ff = 32'h0000_0500; ren = 1'b1; addr = 8'h11;
    tick();
    chk_both("rd1_live", 1'b1, 8'h05);
    ff = 32'h0000_00A5; addr = 8'h10;
    tick();
    chk_both("rd0_live", 1'b1, 8'hA5);

    // Hold reg1 bit4 across two reads: set priority keeps it.
    ff = 32'h0000_1000; addr = 8'h11;
    tick();
    chk_both("hold_rd1", 1'b1, 8'h10);
    tick();
    chk_both("hold_rd2", 1'b1, 8'h10);
    ff = '0; ren = 1'b0;
    tick();
    chk_both("hold_idle", 1'b0, 8'h00);
    ren = 1'b1;
    tick();
    chk_both("hold_kept", 1'b1, 8'h10);
    tick();
    chk_both("hold_clr", 1'b1, 8'h00);
    ren = 1'b0;
    tick();

    // Out-of-range and disabled reads neither respond nor clear.
    ff = 32'h0000_8000;
    tick();
    ff = '0; ren = 1'b1; addr = 8'h14;
    tick();
    chk_both("oor_hi", 1'b0, 8'h00);
    addr = 8'h0F;
    tick();
    chk_both("oor_lo", 1'b0, 8'h00);
    ren = 1'b0; addr = 8'h11;
    tick();
    chk_both("ren_low", 1'b0, 8'h00);
    ren = 1'b1;
    tick();
    chk_both("oor_kept", 1'b1, 8'h80);

    // Top register of the window.
    ff = 32'h5A00_0000; addr = 8'h13;
    tick();
    chk_both("rd3_top", 1'b1, 8'h5A);
    ff = '0; ren = 1'b0;
    tick();

    // Mode gating: instance 1 refuses test-mode reads and keeps its sticky bits.
    ff = 32'h0000_4000;
    tick();
    ff = '0; cfg_mode = 1'b0; test_mode = 1'b1; ren = 1'b1; addr = 8'h11;
    tick();
    chk("test_mode.vld0", {31'd0, rvld0}, 32'd1);
    chk("test_mode.dat0", {24'd0, rdata0}, 32'h40);
    chk("test_mode.vld1", {31'd0, rvld1}, 32'd0);
    chk("test_mode.dat1", {24'd0, rdata1}, 32'h00);
    test_mode = 1'b0;
    tick();
    chk_both("no_mode", 1'b0, 8'h00);
    cfg_mode = 1'b1;
    tick();
    chk("cfg_mode.vld0", {31'd0, rvld0}, 32'd1);
    chk("cfg_mode.dat0", {24'd0, rdata0}, 32'h00);
    chk("cfg_mode.vld1", {31'd0, rvld1}, 32'd1);
    chk("cfg_mode.dat1", {24'd0, rdata1}, 32'h40);
    ren = 1'b0;
    tick();

    // Reset overrides a pending sticky bit, a same-cycle read and a same-cycle set.
    ff = 32'h0000_2000;
    tick();
    rst = 1'b1; ren = 1'b1; addr = 8'h11; ff = 32'h0000_1000;
    tick();
    chk_both("rst_rd", 1'b0, 8'h00);
    rst = 1'b0; ren = 1'b0; ff = '0;
    tick();
    chk_both("rst_after", 1'b0, 8'h00);
    ren = 1'b1;
    tick();
    chk_both("rst_cleared", 1'b1, 8'h00);
    ren = 1'b0;
    tick();

`ifdef RO_STS_BANK_IRQ_EN
    // Interrupt follows enabled sticky bits one cycle late.
    ff = 32'h0001_0000;
    tick();
    ff = '0;
    chk("irq_pre0", {31'd0, irq0}, 32'd0);
    chk("irq_pre1", {31'd0, irq1}, 32'd0);
    tick();
    chk("irq_set0", {31'd0, irq0}, 32'd1);
    chk("irq_set1", {31'd0, irq1}, 32'd1);
    ren = 1'b1; addr = 8'h12;
    tick();
    chk_both("irq_rd2", 1'b1, 8'h01);
    ren = 1'b0;
    tick();
    chk("irq_clr0", {31'd0, irq0}, 32'd0);
    chk("irq_clr1", {31'd0, irq1}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
